// File: rtl/packer_if.sv
// Handshake bundle for the packer: value stream in, packed rows out.
// The master side is the producer/consumer pair around the packer; the slave side is the packer.
interface packer_if #(
   parameter int BIT_WIDTH = 16,
   parameter int PREC_BITS = 5
);
   logic [BIT_WIDTH-1:0] i_in;
   logic [PREC_BITS-1:0] i_prec;
   logic                 i_valid;
   logic                 i_flush;
   logic                 o_ready;
   logic [BIT_WIDTH-1:0] o_out;
   logic                 o_valid;
   logic                 i_out_ready;

   modport master (
      output i_in, i_prec, i_valid, i_flush, i_out_ready,
      input  o_ready, o_out, o_valid
   );

   modport slave (
      input  i_in, i_prec, i_valid, i_flush, i_out_ready,
      output o_ready, o_out, o_valid
   );
endinterface

// File: rtl/packer.sv
// Packs a stream of P-bit values densely into BIT_WIDTH-bit rows, first value at the LSBs.
// Values may straddle rows; a flush emits the zero-padded partial row.
module packer #(
   parameter int BIT_WIDTH = 16,
   parameter int PREC_BITS = 5
) (
   input  logic     clk,
   input  logic     i_rst_n,
   packer_if.slave  bus
);
   localparam int NW = $clog2(2 * BIT_WIDTH);

   typedef enum logic {PACK, FLUSH_PEND} state_e;

   state_e                 state_q, state_d;
   logic [2*BIT_WIDTH-1:0] acc_q, acc_d;
   logic [NW-1:0]          cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0]   out_q, out_d;
   logic                   valid_q, valid_d;

   logic [NW-1:0]          p_eff;
   logic [BIT_WIDTH-1:0]   mask;
   logic [BIT_WIDTH-1:0]   v;
   logic [2*BIT_WIDTH-1:0] t;
   logic [NW-1:0]          n;
   logic                   drain;
   logic                   emit;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      valid_d = valid_q;
      emit    = 1'b0;

      // Precision 0 or out of range means a full-width value.
      if (bus.i_prec == '0 || bus.i_prec > PREC_BITS'(BIT_WIDTH))
         p_eff = NW'(BIT_WIDTH);
      else
         p_eff = NW'(bus.i_prec);

      for (int i = 0; i < BIT_WIDTH; i++)
         mask[i] = (i < int'(p_eff));

      v     = bus.i_in & mask;
      t     = acc_q | ({{BIT_WIDTH{1'b0}}, v} << cnt_q);
      n     = cnt_q + p_eff;
      drain = ~valid_q | bus.i_out_ready;

      bus.o_ready = (state_q == PACK) && drain;

      if (drain)
         valid_d = 1'b0;

      case (state_q)
         PACK: begin
            if (bus.o_ready) begin
               if (bus.i_valid) begin
                  if (n >= NW'(BIT_WIDTH)) begin
                     emit    = 1'b1;
                     out_d   = t[BIT_WIDTH-1:0];
                     valid_d = 1'b1;
                     acc_d   = t >> BIT_WIDTH;
                     cnt_d   = n - NW'(BIT_WIDTH);
                  end else begin
                     acc_d = t;
                     cnt_d = n;
                  end
               end
               // Bits above cnt are always zero, so the remainder is already padded.
               if (bus.i_flush && cnt_d != '0) begin
                  if (emit) begin
                     state_d = FLUSH_PEND;
                  end else begin
                     out_d   = acc_d[BIT_WIDTH-1:0];
                     valid_d = 1'b1;
                     acc_d   = '0;
                     cnt_d   = '0;
                  end
               end
            end
         end
         FLUSH_PEND: begin
            if (drain) begin
               out_d   = acc_q[BIT_WIDTH-1:0];
               valid_d = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = PACK;
            end
         end
         default: state_d = PACK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state_q <= PACK;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign bus.o_out   = out_q;
   assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_packer.sv
// Scoreboard bench for packer: directed stimulus pushes expected rows, a monitor pops
// and compares every row the DUT hands downstream.
module tb_packer;
   localparam int W  = 16;
   localparam int PB = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   packer_if #(.BIT_WIDTH(W), .PREC_BITS(PB)) bus();

   packer #(.BIT_WIDTH(W), .PREC_BITS(PB)) dut (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int total  = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: a row is consumed on the next posedge when valid & ready at negedge.
   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_row: got %0h expected no row", bus.o_out);
         end else begin
            chk("row", bus.o_out, exp_q.pop_front());
         end
      end
   end

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!bus.o_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.o_ready) begin
         total++;
         $display("FAIL accept_timeout: got o_ready=0 expected o_ready=1 within 50 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] val, input logic [PB-1:0] p,
                       input logic vld, input logic fl);
      bus.i_in    = val;
      bus.i_prec  = p;
      bus.i_valid = vld;
      bus.i_flush = fl;
      wait_accept();
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
   endtask

   initial begin
      bus.i_in        = '0;
      bus.i_prec      = '0;
      bus.i_valid     = 1'b0;
      bus.i_flush     = 1'b0;
      bus.i_out_ready = 1'b1;

      idle(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
      chk("reset_o_out",   32'(bus.o_out),   32'd0);
      chk("reset_o_ready", 32'(bus.o_ready), 32'd1);
      idle(1);

      // 1: P=4 nibbles
      exp_q.push_back(16'h4321);
      send(16'h1, 5'd4, 1'b1, 1'b0);
      send(16'h2, 5'd4, 1'b1, 1'b0);
      send(16'h3, 5'd4, 1'b1, 1'b0);
      send(16'h4, 5'd4, 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_latency_valid", 32'(bus.o_valid), 32'd1);
      idle(2);

      // 2: P=5 straddling a row, then a bare flush
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h000F);
      repeat (4) send(16'h1F, 5'd5, 1'b1, 1'b0);
      send(16'h0, 5'd0, 1'b0, 1'b1);
      idle(3);

      // 3: full-width passthrough, back to back
      exp_q.push_back(16'hABCD);
      exp_q.push_back(16'h1234);
      send(16'hABCD, 5'd16, 1'b1, 1'b0);
      send(16'h1234, 5'd16, 1'b1, 1'b0);
      idle(3);

      // 4: backpressure holds the row and stalls input
      bus.i_out_ready = 1'b0;
      send(16'h1111, 5'd16, 1'b1, 1'b0);
      bus.i_in    = 16'h2222;
      bus.i_prec  = 5'd16;
      bus.i_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("bp_o_ready", 32'(bus.o_ready), 32'd0);
      chk("bp_o_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_o_out",   32'(bus.o_out),   32'h1111);
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      @(posedge clk);
      #1;
      bus.i_out_ready = 1'b1;
      wait_accept();
      bus.i_valid = 1'b0;
      idle(3);

      // 5: flush on a value that also completes a row
      exp_q.push_back(16'hBAAA);
      exp_q.push_back(16'h0005);
      repeat (3) send(16'hA, 5'd4, 1'b1, 1'b0);
      send(16'h5B, 5'd8, 1'b1, 1'b1);
      @(negedge clk);
      chk("t5_pend_o_ready", 32'(bus.o_ready), 32'd0);
      chk("t5_first_row",    32'(bus.o_out),   32'hBAAA);
      idle(3);

      // 6a: masking of high bits and precision 0 treated as full width
      exp_q.push_back(16'h3213);
      exp_q.push_back(16'h5A5A);
      send(16'hFFF3, 5'd4, 1'b1, 1'b0);
      send(16'hFFF1, 5'd4, 1'b1, 1'b0);
      send(16'h0002, 5'd4, 1'b1, 1'b0);
      send(16'h0003, 5'd4, 1'b1, 1'b0);
      send(16'h5A5A, 5'd0, 1'b1, 1'b0);
      idle(3);

      // 6b: reset discards a partial row
      send(16'hFFF3, 5'd4, 1'b1, 1'b0);
      send(16'h0007, 5'd4, 1'b1, 1'b0);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_reset_o_valid", 32'(bus.o_valid), 32'd0);
      idle(1);
      send(16'h0, 5'd0, 1'b0, 1'b1);
      idle(4);
      @(negedge clk);
      chk("t6_flush_empty", 32'(bus.o_valid), 32'd0);

      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
